// File: rtl/mem_write_buffer.sv
//------------------------------------------------------------------------------
// Module   : mem_write_buffer
// Purpose  : Circular store buffer between CPU and data memory, drained one
//            entry per cycle. Load forwarding is built only when
//            MEM_WRITE_BUFFER_FWD_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_write_buffer #(
   parameter int SIZE  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       St_Req,
   input  logic [SIZE-1:0]            St_Addr,
   input  logic [SIZE-1:0]            St_Data,
   output logic                       St_Ready,
   input  logic [SIZE-1:0]            Ld_Addr,
   output logic                       Ld_Hit,
   output logic [SIZE-1:0]            Ld_Data,
   input  logic                       Drain_Hold,
   output logic                       Mem_WE,
   output logic [SIZE-1:0]            Mem_Addr,
   output logic [SIZE-1:0]            Mem_Data,
   output logic [$clog2(DEPTH):0]     Count,
   output logic                       Empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [SIZE-1:0] addr_q [DEPTH];
   logic [SIZE-1:0] data_q [DEPTH];

   logic w_accept;
   logic w_drain;

   assign St_Ready = (count_q < CW'(DEPTH));
   assign Empty    = (count_q == '0);
   assign Count    = count_q;
   assign Mem_WE   = !Empty && !Drain_Hold;
   assign Mem_Addr = Empty ? '0 : addr_q[head_q];
   assign Mem_Data = Empty ? '0 : data_q[head_q];

   assign w_accept = St_Req && St_Ready;
   assign w_drain  = Mem_WE;

   // DEPTH is a power of two, so pointer wrap falls out of the PW-bit adders.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(w_accept) - CW'(w_drain);
      if (w_accept) tail_d = tail_q + PW'(1);
      if (w_drain)  head_d = head_q + PW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payload carries no reset; validity is derived from head/count.
   always_ff @(posedge CLK) begin
      if (!RST && w_accept) begin
         addr_q[tail_q] <= St_Addr;
         data_q[tail_q] <= St_Data;
      end
   end

`ifdef MEM_WRITE_BUFFER_FWD_EN
   // Walk oldest to youngest so the last match is the youngest store.
   always_comb begin
      logic [PW-1:0] idx;
      Ld_Hit  = 1'b0;
      Ld_Data = '0;
      idx     = head_q;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_q[idx] == Ld_Addr)) begin
            Ld_Hit  = 1'b1;
            Ld_Data = data_q[idx];
         end
      end
   end
`else
   logic w_unused_ld_addr;
   assign w_unused_ld_addr = ^Ld_Addr;
   assign Ld_Hit  = 1'b0;
   assign Ld_Data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_write_buffer
// Purpose  : Self-checking bench for mem_write_buffer against a queue model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_buffer;

   localparam int SIZE  = 32;
   localparam int DEPTH = 4;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            St_Req = 1'b0;
   logic [SIZE-1:0] St_Addr = '0;
   logic [SIZE-1:0] St_Data = '0;
   logic            St_Ready;
   logic [SIZE-1:0] Ld_Addr = '0;
   logic            Ld_Hit;
   logic [SIZE-1:0] Ld_Data;
   logic            Drain_Hold = 1'b0;
   logic            Mem_WE;
   logic [SIZE-1:0] Mem_Addr;
   logic [SIZE-1:0] Mem_Data;
   logic [2:0]      Count;
   logic            Empty;

   mem_write_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .St_Req(St_Req), .St_Addr(St_Addr), .St_Data(St_Data), .St_Ready(St_Ready),
      .Ld_Addr(Ld_Addr), .Ld_Hit(Ld_Hit), .Ld_Data(Ld_Data),
      .Drain_Hold(Drain_Hold),
      .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
      .Count(Count), .Empty(Empty)
   );

   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_pass  = 0;
   bit model_ok = 1'b0;

   // Model: pending stores in acceptance order, {addr, data}.
   logic [63:0] q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   always @(posedge CLK) begin
      if (RST) begin
         q.delete();
         model_ok <= 1'b1;
      end else begin
         bit acc, drn;
         acc = St_Req && (q.size() < DEPTH);
         drn = (q.size() > 0) && !Drain_Hold;
         if (drn) void'(q.pop_front());
         if (acc) q.push_back({St_Addr, St_Data});
      end
   end

   always @(negedge CLK) begin
      if (model_ok) begin
         int          cnt;
         logic        e_hit;
         logic [31:0] e_ld;
         cnt = q.size();
         chk("St_Ready", 32'(St_Ready), 32'(cnt < DEPTH));
         chk("Count",    32'(Count),    32'(cnt));
         chk("Empty",    32'(Empty),    32'(cnt == 0));
         chk("Mem_WE",   32'(Mem_WE),   32'((cnt > 0) && !Drain_Hold));
         chk("Mem_Addr", Mem_Addr, (cnt > 0) ? q[0][63:32] : 32'h0);
         chk("Mem_Data", Mem_Data, (cnt > 0) ? q[0][31:0]  : 32'h0);
         e_hit = 1'b0;
         e_ld  = 32'h0;
`ifdef MEM_WRITE_BUFFER_FWD_EN
         for (int i = cnt - 1; i >= 0; i--) begin
            if (!e_hit && q[i][63:32] == Ld_Addr) begin
               e_hit = 1'b1;
               e_ld  = q[i][31:0];
            end
         end
`endif
         chk("Ld_Hit",  32'(Ld_Hit), 32'(e_hit));
         chk("Ld_Data", Ld_Data, e_ld);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      St_Req  = 1'b1;
      St_Addr = a;
      St_Data = d;
      tick(1);
      St_Req  = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      tick(2);
      RST = 1'b0;
      #1;
      chk("rst_Count", 32'(Count), 32'd0);
      chk("rst_Ready", 32'(St_Ready), 32'd1);
      chk("rst_MemWE", 32'(Mem_WE), 32'd0);

      // single store, drained on the next cycle
      store(32'h10, 32'hAAAA5555);
      #1;
      chk("one_WE",   32'(Mem_WE), 32'd1);
      chk("one_Addr", Mem_Addr, 32'h10);
      chk("one_Data", Mem_Data, 32'hAAAA5555);
      tick(1);
      chk("one_Empty", 32'(Empty), 32'd1);

      // fill under hold, fifth store dropped, then drain in order
      Drain_Hold = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         store(32'(i), 32'h100 + 32'(i));
         if (i == 4) begin
            chk("full_Ready", 32'(St_Ready), 32'd0);
            chk("full_Count", 32'(Count), 32'd4);
         end
      end
      chk("drop_Count", 32'(Count), 32'd4);
      Drain_Hold = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_Addr", Mem_Addr, 32'(i));
         tick(1);
      end
      chk("drain_Empty", 32'(Empty), 32'd1);

      // full with continuous requests: refuse while full, then steady at 3
      Drain_Hold = 1'b1;
      for (int i = 0; i < 4; i++) store(32'h30 + 32'(i), 32'h300 + 32'(i));
      Drain_Hold = 1'b0;
      St_Req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         St_Addr = 32'h40 + 32'(i);
         St_Data = 32'h400 + 32'(i);
         tick(1);
         chk("steady_Count", 32'(Count), 32'd3);
      end
      St_Req = 1'b0;
      tick(4);

      // forwarding of youngest matching store
      Drain_Hold = 1'b1;
      store(32'h20, 32'd1);
      store(32'h20, 32'd2);
      Ld_Addr = 32'h20;
      #1;
`ifdef MEM_WRITE_BUFFER_FWD_EN
      chk("fwd_Hit",  32'(Ld_Hit), 32'd1);
      chk("fwd_Data", Ld_Data, 32'd2);
`else
      chk("fwd_Hit",  32'(Ld_Hit), 32'd0);
`endif
      Ld_Addr = 32'h24;
      #1;
      chk("miss_Hit",  32'(Ld_Hit), 32'd0);
      chk("miss_Data", Ld_Data, 32'd0);

      // reset beats a simultaneous store
      store(32'h50, 32'h5);
      RST = 1'b1;
      store(32'h51, 32'h6);
      RST = 1'b0;
      Drain_Hold = 1'b0;
      #1;
      chk("rst2_Count", 32'(Count), 32'd0);
      chk("rst2_MemWE", 32'(Mem_WE), 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         RST        = ($urandom_range(0, 199) == 0);
         St_Req     = ($urandom_range(0, 9) < 6);
         St_Addr    = 32'($urandom_range(0, 7));
         St_Data    = $urandom;
         Drain_Hold = ($urandom_range(0, 9) < 4);
         Ld_Addr    = 32'($urandom_range(0, 7));
         tick(1);
      end
      RST = 1'b0;
      St_Req = 1'b0;
      Drain_Hold = 1'b0;
      tick(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 32, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the posedge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port St_Req  input  1  CPU store request.
REQ-006 SHALL have port St_Addr  input  SIZE  store address.
REQ-007 SHALL have port St_Data  input  SIZE  store data.
REQ-008 SHALL have port St_Ready  output  1  a store is accepted this cycle (buffer not full).
REQ-009 SHALL have port Ld_Addr  input  SIZE  CPU load address for forwarding lookup.
REQ-010 SHALL have port Ld_Hit  output  1  Ld_Addr matches a buffered store.
REQ-011 SHALL have port Ld_Data  output  SIZE  forwarded data.
REQ-012 SHALL have port Drain_Hold  input  1  suppresses draining this cycle.
REQ-013 SHALL have port Mem_WE  output  1  write enable to the data memory.
REQ-014 SHALL have port Mem_Addr  output  SIZE  write address to the data memory.
REQ-015 SHALL have port Mem_Data  output  SIZE  write data to the data memory.
REQ-016 SHALL have port Count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-017 SHALL have port Empty  output  1  Count == 0.

Function
REQ-018 SHALL hold stores in a circular FIFO with head/tail pointers that wrap from DEPTH-1 to 0.
REQ-019 SHALL drive St_Ready = (Count < DEPTH); when full it SHALL be low even if a drain occurs in the same cycle.
REQ-020 SHALL write {St_Addr, St_Data} at tail and advance tail on a posedge where St_Req && St_Ready; St_Req while not ready SHALL be ignored with no state change.
REQ-021 SHALL drive Mem_WE = !Empty && !Drain_Hold combinationally, with Mem_Addr/Mem_Data taken from the head entry; Mem_Addr/Mem_Data SHALL be 0 when Empty.
REQ-022 SHALL advance head on a posedge where Mem_WE is high; the outputs are therefore stable through the following negedge memory write.
REQ-023 SHALL apply accept and drain in the same cycle together: Count unchanged, both pointers advance.
REQ-024 SHALL drain strictly in acceptance order, one entry per cycle; a store accepted at a posedge is drainable no earlier than the next cycle (minimum latency 1 cycle, Empty-to-Mem_WE).
REQ-025 SHALL compare Ld_Addr combinationally against all valid entries; Ld_Hit SHALL be high on any match and Ld_Data SHALL be the data of the youngest matching entry.
REQ-026 SHALL include the head entry in forwarding during the cycle it drains; St_Data presented in the current cycle SHALL NOT be forwarded.
REQ-027 SHALL drive Ld_Data = 0 when Ld_Hit is low.

Reset
REQ-028 SHALL, on a posedge with RST high, clear head, tail and Count to 0 and invalidate all entries, discarding pending stores, including any mid-drain.
REQ-029 SHALL produce, in the cycle after reset: St_Ready=1, Empty=1, Mem_WE=0, Mem_Addr=0, Mem_Data=0, Ld_Hit=0, Ld_Data=0, Count=0.
REQ-030 SHALL give RST priority over St_Req and drain in the same cycle; entry data registers need not be cleared.

Configuration
REQ-031 SHALL compile load forwarding (REQ-025..027) only when macro MEM_WRITE_BUFFER_FWD_EN is defined.
REQ-032 SHALL, without MEM_WRITE_BUFFER_FWD_EN, tie Ld_Hit=0 and Ld_Data=0, contain no comparators, and leave all other behaviour unchanged.

Verification
REQ-033 Reset, then one store Addr=0x10 Data=0xAAAA5555 -> next cycle Mem_WE=1, Mem_Addr=0x10, Mem_Data=0xAAAA5555; cycle after, Empty=1.
REQ-034 Drain_Hold=1, 5 consecutive stores Addr=1..5 -> St_Ready low after the 4th and Count=4; the 5th is dropped; release hold -> writes drain to Addr 1,2,3,4 on 4 consecutive cycles.
REQ-035 Full buffer, Drain_Hold=0, St_Req=1 -> no accept while full; once Count=3, accept and drain in the same cycle keep Count=3; pointers wrap correctly.
REQ-036 (FWD_EN) Stores Addr=0x20 Data=1 then Addr=0x20 Data=2, held -> Ld_Addr=0x20 gives Ld_Hit=1, Ld_Data=2; Ld_Addr=0x24 gives Ld_Hit=0, Ld_Data=0; without macro Ld_Hit=0 always.
REQ-037 Three entries buffered, RST asserted for one cycle alongside St_Req -> next cycle Count=0, Mem_WE=0, nothing written to memory, the store is not accepted.
